hazard_scoreboard_unit: RTL

Parametrised successor of the single-cycle load-use detector. It tracks every in-flight long-latency writeback (variable-latency loads, multi-cycle MUL/DIV) in a per-register pending scoreboard. It raises RAW, WAW and structural stalls for the instruction in ID, and merges branch/jump redirect flushes from EX. It sits beside the ID stage and drives PC/IF-ID freeze and the IF/ID and ID/EX bubble controls, plus sticky diagnostics.

---
 rtl/hazard_scoreboard_unit_if.sv | 63 ++++++
 rtl/hazard_scoreboard_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_unit_if
//  Description : Bundle of the ID-side, EX-issue and writeback-completion
//                signals that feed the hazard scoreboard, together with the
//                pipeline-control and diagnostic outputs it drives.
//                  master : pipeline side (drives requests, observes controls)
//                  slave  : scoreboard side
//  Ports       : issue_valid_ex/issue_rd_ex    long op leaving EX
//                complete_valid/complete_rd    long op writing back
//                valid_id, rs1/rs2 addr+used, rd_addr_id/rd_write_id,
//                is_long_id                    instruction currently in ID
//                redirect_ex                   taken branch/jump in EX
//                stall_pipeline, flush_id_ex, flush_if_id   pipeline control
//                pending_count, stall_cycles, timeout_err,
//                protocol_err                  status / sticky diagnostics
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 8
);
    localparam int c_pc_w = $clog2(MAX_PENDING + 1);

    logic                  issue_valid_ex;
    logic [REG_ADDR_W-1:0] issue_rd_ex;
    logic                  complete_valid;
    logic [REG_ADDR_W-1:0] complete_rd;
    logic                  valid_id;
    logic [REG_ADDR_W-1:0] rs1_addr_id;
    logic [REG_ADDR_W-1:0] rs2_addr_id;
    logic                  rs1_used_id;
    logic                  rs2_used_id;
    logic [REG_ADDR_W-1:0] rd_addr_id;
    logic                  rd_write_id;
    logic                  is_long_id;
    logic                  redirect_ex;
    logic                  stall_pipeline;
    logic                  flush_id_ex;
    logic                  flush_if_id;
    logic [c_pc_w-1:0]     pending_count;
    logic [CNT_W-1:0]      stall_cycles;
    logic                  timeout_err;
    logic                  protocol_err;

    modport master (
        output issue_valid_ex, issue_rd_ex, complete_valid, complete_rd,
               valid_id, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
               rd_addr_id, rd_write_id, is_long_id, redirect_ex,
        input  stall_pipeline, flush_id_ex, flush_if_id, pending_count,
               stall_cycles, timeout_err, protocol_err
    );

    modport slave (
        input  issue_valid_ex, issue_rd_ex, complete_valid, complete_rd,
               valid_id, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
               rd_addr_id, rd_write_id, is_long_id, redirect_ex,
        output stall_pipeline, flush_id_ex, flush_if_id, pending_count,
               stall_cycles, timeout_err, protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_unit
//  Description : Per-register pending scoreboard for long-latency writebacks
//                (variable-latency loads, MUL/DIV). Detects RAW, WAW and
//                structural hazards for the instruction in ID, merges EX
//                redirect flushes, and keeps stall-length and sticky error
//                diagnostics.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - hazard_scoreboard_unit_if.slave (requests in,
//                         pipeline controls and diagnostics out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W    = 5,
    parameter int MAX_PENDING   = 4,
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    hazard_scoreboard_unit_if.slave bus
);

    localparam int                c_num_regs = 2 ** REG_ADDR_W;
    localparam int                c_pc_w     = $clog2(MAX_PENDING + 1);
    localparam logic [c_pc_w-1:0] c_max_pend = c_pc_w'(MAX_PENDING);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [31:0]       c_timeout_last = 32'(STALL_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_num_regs-1:0] r_pend;
    logic [c_pc_w-1:0]     r_pending_count;
    logic [CNT_W-1:0]      r_stall_cycles;
    logic                  r_timeout_err;
    logic                  r_protocol_err;

    // ------------------------------------------------------------------------
    // Issue / completion qualification
    // ------------------------------------------------------------------------
    logic w_issue_req;
    logic w_issue_acc;
    logic w_issue_err;
    logic w_full;
    logic w_comp_req;
    logic w_comp_acc;
    logic w_comp_err;

    assign w_full      = (r_pending_count == c_max_pend);
    // x0 is never tracked, so issues and completions to it are simply dropped.
    assign w_issue_req = bus.issue_valid_ex && (bus.issue_rd_ex != '0);
    assign w_issue_acc = w_issue_req && !w_full;
    assign w_issue_err = w_issue_req && w_full;
    assign w_comp_req  = bus.complete_valid && (bus.complete_rd != '0);
    assign w_comp_acc  = w_comp_req && r_pend[bus.complete_rd];
    assign w_comp_err  = w_comp_req && !r_pend[bus.complete_rd];

    // Clear first, then set: when the same rd completes and issues in one
    // cycle the issuing instruction is younger, so the entry stays pending.
    logic [c_num_regs-1:0] w_pend_next;
    always_comb begin
        w_pend_next = r_pend;
        if (w_comp_acc) begin
            w_pend_next[bus.complete_rd] = 1'b0;
        end
        if (w_issue_acc) begin
            w_pend_next[bus.issue_rd_ex] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    logic [c_pc_w-1:0] w_count_next;
    always_comb begin
        w_count_next = r_pending_count;
        case ({w_issue_acc, w_comp_acc})
            2'b10:   w_count_next = r_pending_count + c_pc_w'(1);
            2'b01:   w_count_next = r_pending_count - c_pc_w'(1);
            default: w_count_next = r_pending_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Hazard detection for the instruction in ID
    // ------------------------------------------------------------------------
    // A register is "busy" if it is pending and not being written back right
    // now, or if a long op targeting it is leaving EX this very cycle (the
    // scoreboard bit only appears at the next edge, so match it directly).
    // The issue match also covers same-cycle issue+complete to one rd.
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rd_busy;

    assign w_rs1_busy =
        (r_pend[bus.rs1_addr_id] &&
         !(bus.complete_valid && (bus.complete_rd == bus.rs1_addr_id))) ||
        (bus.issue_valid_ex && (bus.issue_rd_ex == bus.rs1_addr_id));
    assign w_rs2_busy =
        (r_pend[bus.rs2_addr_id] &&
         !(bus.complete_valid && (bus.complete_rd == bus.rs2_addr_id))) ||
        (bus.issue_valid_ex && (bus.issue_rd_ex == bus.rs2_addr_id));
    assign w_rd_busy =
        (r_pend[bus.rd_addr_id] &&
         !(bus.complete_valid && (bus.complete_rd == bus.rd_addr_id))) ||
        (bus.issue_valid_ex && (bus.issue_rd_ex == bus.rd_addr_id));

    logic w_raw;
    logic w_waw;
    logic w_struct;
    logic w_hazard;

    assign w_raw = bus.valid_id &&
                   ((bus.rs1_used_id && (bus.rs1_addr_id != '0) && w_rs1_busy) ||
                    (bus.rs2_used_id && (bus.rs2_addr_id != '0) && w_rs2_busy));
    assign w_waw = bus.valid_id && bus.rd_write_id &&
                   (bus.rd_addr_id != '0) && w_rd_busy;
    // A completion this cycle frees a slot before the ID op can issue.
    assign w_struct = bus.valid_id && bus.is_long_id && w_full &&
                      !bus.complete_valid;
    assign w_hazard = w_raw || w_waw || w_struct;

    // ------------------------------------------------------------------------
    // Pipeline control: a redirect squashes the ID instruction anyway, so it
    // overrides any stall and is not counted as one.
    // ------------------------------------------------------------------------
    logic w_stall;
    logic w_flush_id_ex;
    logic w_flush_if_id;

    always_comb begin
        w_stall       = 1'b0;
        w_flush_id_ex = 1'b0;
        w_flush_if_id = 1'b0;
        if (bus.redirect_ex) begin
            w_flush_id_ex = 1'b1;
            w_flush_if_id = 1'b1;
        end else if (w_hazard) begin
            w_stall       = 1'b1;
            w_flush_id_ex = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend          <= '0;
            r_pending_count <= '0;
            r_stall_cycles  <= '0;
            r_timeout_err   <= 1'b0;
            r_protocol_err  <= 1'b0;
        end else begin
            r_pend          <= w_pend_next;
            r_pending_count <= w_count_next;

            if (w_stall) begin
                if (r_stall_cycles != c_cnt_max) begin
                    r_stall_cycles <= r_stall_cycles + CNT_W'(1);
                end
            end else begin
                r_stall_cycles <= '0;
            end

            // r_stall_cycles counts earlier stall cycles, so reaching
            // STALL_TIMEOUT-1 while stalling marks the STALL_TIMEOUT-th one.
            if (w_stall && (32'(r_stall_cycles) >= c_timeout_last)) begin
                r_timeout_err <= 1'b1;
            end

            if (w_issue_err || w_comp_err) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.stall_pipeline = w_stall;
    assign bus.flush_id_ex    = w_flush_id_ex;
    assign bus.flush_if_id    = w_flush_if_id;
    assign bus.pending_count  = r_pending_count;
    assign bus.stall_cycles   = r_stall_cycles;
    assign bus.timeout_err    = r_timeout_err;
    assign bus.protocol_err   = r_protocol_err;

endmodule
`default_nettype wire
